// File: rtl/voicemail_ctrl.sv
// Voicemail record/playback controller: sample FIFO between the AC97 sample tick and a
// single-outstanding-word storage port. Define VOICEMAIL_BEEP_EN for a square-wave beep before capture.
module voicemail_ctrl #(
   parameter int SLOT_LOG2    = 16,
   parameter int MAX_MSGS     = 8,
   parameter int MEM_AW       = 19,
   parameter int FIFO_LOG2    = 4,
   parameter int BEEP_SAMPLES = 4800,
   parameter int BEEP_HALF    = 24,
   localparam int MSG_W       = $clog2(MAX_MSGS),
   localparam int CNT_W       = MSG_W + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        vm_cmd,
   input  logic              vm_cmd_stb,
   input  logic [MSG_W-1:0]  vm_sel,
   input  logic              card_present,
   input  logic              ready,
   input  logic [15:0]       audio_in_data,
   output logic [15:0]       audio_out_data,
   output logic [3:0]        vm_status,
   output logic [CNT_W-1:0]  msg_count,
   output logic              overflow,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack
);
   localparam int PTR_W = SLOT_LOG2 + 1;
   localparam int FC_W  = FIFO_LOG2 + 1;
   localparam logic [PTR_W-1:0] SLOT_WORDS = {1'b1, {SLOT_LOG2{1'b0}}};
   localparam logic [FC_W-1:0]  DEPTH      = {1'b1, {FIFO_LOG2{1'b0}}};

   localparam logic [2:0] CMD_RECORD = 3'd1, CMD_STOP = 3'd2, CMD_PLAY = 3'd3,
                          CMD_DEL_LAST = 3'd4, CMD_DEL_ALL = 3'd5;

   typedef enum logic [2:0] {S_NOCARD, S_IDLE, S_REC, S_FLUSH, S_PLAY} state_t;

   state_t           state_q, state_d;
   logic [3:0]       status_q, status_d;
   logic             full_q, full_d;
   logic [CNT_W-1:0] msg_count_q, msg_count_d;
   logic             overflow_q, overflow_d;
   logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]      mem_wdata_q, mem_wdata_d, audio_q, audio_d;
   logic [MSG_W-1:0] slot_q, slot_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             stop_q, stop_d;
   logic [PTR_W-1:0] len_q [MAX_MSGS];
   logic [PTR_W-1:0] len_d [MAX_MSGS];

   logic [15:0]          fifo_mem [2**FIFO_LOG2];
   logic [FIFO_LOG2-1:0] fwp_q, fwp_d, frp_q, frp_d;
   logic [FC_W-1:0]      fcnt_q, fcnt_d;
   logic                 push, pop, fclr;
   logic [15:0]          push_data, fifo_head;

   logic             ack, stop_cmd, beep_on;
   logic [PTR_W-1:0] total;

`ifdef VOICEMAIL_BEEP_EN
   localparam int BEEP_W = $clog2(BEEP_SAMPLES + 1);
   localparam int HALF_W = $clog2(BEEP_HALF + 1);
   logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
   logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
   logic              beep_ph_q, beep_ph_d;
   assign beep_on = (beep_cnt_q != '0);
`else
   assign beep_on = 1'b0;
`endif

   assign ack       = mem_req_q & mem_ack;
   assign stop_cmd  = vm_cmd_stb && (vm_cmd == CMD_STOP);
   assign fifo_head = fifo_mem[frp_q];
   // Words captured so far, counting the one in flight (writer pops on ack, not on issue).
   assign total     = ptr_q + PTR_W'(fcnt_q);

   function automatic logic [MEM_AW-1:0] slot_addr(input logic [MSG_W-1:0] s,
                                                   input logic [SLOT_LOG2-1:0] p);
      return MEM_AW'({s, p});
   endfunction

   always_comb begin
      state_d     = state_q;
      full_d      = 1'b0;
      msg_count_d = msg_count_q;
      overflow_d  = overflow_q;
      mem_req_d   = mem_req_q & ~ack;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      audio_d     = audio_q;
      slot_d      = slot_q;
      ptr_d       = ptr_q;
      stop_d      = stop_q;
      len_d       = len_q;
      push        = 1'b0;
      push_data   = audio_in_data;
      pop         = 1'b0;
      fclr        = 1'b0;
`ifdef VOICEMAIL_BEEP_EN
      beep_cnt_d  = beep_cnt_q;
      half_cnt_d  = half_cnt_q;
      beep_ph_d   = beep_ph_q;
`endif
      case (state_q)
         S_NOCARD: if (card_present) state_d = S_IDLE;
         S_IDLE: if (vm_cmd_stb) begin
            case (vm_cmd)
               CMD_RECORD: if (msg_count_q == CNT_W'(MAX_MSGS)) full_d = 1'b1;
                  else begin
                     state_d    = S_REC;
                     ptr_d      = '0;
                     slot_d     = msg_count_q[MSG_W-1:0];
                     overflow_d = 1'b0;
                     audio_d    = '0;
`ifdef VOICEMAIL_BEEP_EN
                     beep_cnt_d = BEEP_W'(BEEP_SAMPLES);
                     half_cnt_d = '0;
                     beep_ph_d  = 1'b0;
`endif
                  end
               CMD_PLAY: if (CNT_W'(vm_sel) < msg_count_q) begin
                  state_d    = S_PLAY;
                  ptr_d      = '0;
                  slot_d     = vm_sel;
                  overflow_d = 1'b0;
                  stop_d     = 1'b0;
               end
               CMD_DEL_LAST: if (msg_count_q != '0) begin
                  msg_count_d = msg_count_q - 1'b1;
                  len_d[MSG_W'(msg_count_q - 1'b1)] = '0;
               end
               CMD_DEL_ALL: begin
                  msg_count_d = '0;
                  for (int i = 0; i < MAX_MSGS; i++) len_d[i] = '0;
               end
               default: ;
            endcase
         end
         S_REC, S_FLUSH: begin
            if (ack) begin
               ptr_d = ptr_q + 1'b1;
               pop   = 1'b1;
            end
            if (!mem_req_q && fcnt_q != '0) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = slot_addr(slot_q, ptr_q[SLOT_LOG2-1:0]);
               mem_wdata_d = fifo_head;
            end
            if (state_q == S_FLUSH) begin
               if (fcnt_q == '0 && !mem_req_q) begin
                  len_d[slot_q] = ptr_q;
                  msg_count_d   = msg_count_q + 1'b1;
                  state_d       = S_IDLE;
               end
            end else if (beep_on) begin
`ifdef VOICEMAIL_BEEP_EN
               // Abandoning during the beep leaves no slot behind.
               if (stop_cmd) begin
                  state_d    = S_IDLE;
                  audio_d    = '0;
                  beep_cnt_d = '0;
               end else if (ready) begin
                  audio_d    = beep_ph_q ? 16'hE000 : 16'h2000;
                  beep_cnt_d = beep_cnt_q - 1'b1;
                  if (half_cnt_q == HALF_W'(BEEP_HALF - 1)) begin
                     half_cnt_d = '0;
                     beep_ph_d  = ~beep_ph_q;
                  end else half_cnt_d = half_cnt_q + 1'b1;
               end
`endif
            end else begin
               if (stop_cmd || total == SLOT_WORDS) state_d = S_FLUSH;
               if (ready) begin
                  audio_d = '0;
                  if (total != SLOT_WORDS) begin
                     if (fcnt_q == DEPTH) overflow_d = 1'b1;
                     else push = 1'b1;
                  end
               end
            end
         end
         S_PLAY: begin
            if (ack) begin
               ptr_d = ptr_q + 1'b1;
               if (!stop_q) begin
                  push      = 1'b1;
                  push_data = mem_rdata;
               end
            end
            if (stop_q || stop_cmd) begin
               // A read already on the bus must complete before we leave; its data is dropped.
               if (!mem_req_q || ack) begin
                  fclr    = 1'b1;
                  state_d = S_IDLE;
                  audio_d = '0;
                  stop_d  = 1'b0;
               end else stop_d = 1'b1;
            end else begin
               if (!mem_req_q && ptr_q < len_q[slot_q] && fcnt_q < DEPTH) begin
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = slot_addr(slot_q, ptr_q[SLOT_LOG2-1:0]);
               end
               if (len_q[slot_q] == '0) begin
                  state_d = S_IDLE;
                  audio_d = '0;
               end else if (ready) begin
                  if (fcnt_q != '0) begin
                     pop     = 1'b1;
                     audio_d = fifo_head;
                  end else if (ptr_q < len_q[slot_q]) begin
                     audio_d    = '0;
                     overflow_d = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     audio_d = '0;
                  end
               end
            end
         end
         default: state_d = S_NOCARD;
      endcase
      if (!card_present) begin
         state_d     = S_NOCARD;
         mem_req_d   = 1'b0;
         fclr        = 1'b1;
         msg_count_d = '0;
         audio_d     = '0;
         stop_d      = 1'b0;
         for (int i = 0; i < MAX_MSGS; i++) len_d[i] = '0;
      end
   end

   always_comb begin
      fwp_d  = fwp_q;
      frp_d  = frp_q;
      fcnt_d = fcnt_q;
      if (fclr) begin
         fwp_d  = '0;
         frp_d  = '0;
         fcnt_d = '0;
      end else begin
         if (push) fwp_d = fwp_q + 1'b1;
         if (pop)  frp_d = frp_q + 1'b1;
         if (push && !pop) fcnt_d = fcnt_q + 1'b1;
         else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
      end
   end

   always_comb begin
      case (state_q)
         S_IDLE:  status_d = 4'd1;
         S_REC:   status_d = 4'd2;
         S_PLAY:  status_d = 4'd3;
         S_FLUSH: status_d = 4'd4;
         default: status_d = 4'd0;
      endcase
      if (full_q) status_d = 4'd5;
      if (!card_present) status_d = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (push && !fclr) fifo_mem[fwp_q] <= push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_NOCARD;
         status_q    <= '0;
         full_q      <= 1'b0;
         msg_count_q <= '0;
         overflow_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         audio_q     <= '0;
         slot_q      <= '0;
         ptr_q       <= '0;
         stop_q      <= 1'b0;
         len_q       <= '{default: '0};
         fwp_q       <= '0;
         frp_q       <= '0;
         fcnt_q      <= '0;
`ifdef VOICEMAIL_BEEP_EN
         beep_cnt_q  <= '0;
         half_cnt_q  <= '0;
         beep_ph_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         full_q      <= full_d;
         msg_count_q <= msg_count_d;
         overflow_q  <= overflow_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         audio_q     <= audio_d;
         slot_q      <= slot_d;
         ptr_q       <= ptr_d;
         stop_q      <= stop_d;
         len_q       <= len_d;
         fwp_q       <= fwp_d;
         frp_q       <= frp_d;
         fcnt_q      <= fcnt_d;
`ifdef VOICEMAIL_BEEP_EN
         beep_cnt_q  <= beep_cnt_d;
         half_cnt_q  <= half_cnt_d;
         beep_ph_q   <= beep_ph_d;
`endif
      end
   end

   assign audio_out_data = audio_q;
   assign vm_status      = status_q;
   assign msg_count      = msg_count_q;
   assign overflow       = overflow_q;
   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_voicemail_ctrl.sv
// Scoreboard bench for voicemail_ctrl: memory model with 3-cycle ack, write and playback monitors.
module tb_voicemail_ctrl;
   localparam int SL = 5;   // 32-word slots so the slot-full boundary is reachable
   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  vm_cmd = '0;
   logic        vm_cmd_stb = 1'b0;
   logic [2:0]  vm_sel = '0;
   logic        card_present = 1'b1;
   logic        ready = 1'b0;
   logic [15:0] audio_in_data = '0;
   logic [15:0] audio_out_data;
   logic [3:0]  vm_status;
   logic [3:0]  msg_count;
   logic        overflow, mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   voicemail_ctrl #(.SLOT_LOG2(SL), .MAX_MSGS(8), .MEM_AW(AW), .FIFO_LOG2(4)) dut (
      .clk(clk), .reset_n(reset_n), .vm_cmd(vm_cmd), .vm_cmd_stb(vm_cmd_stb), .vm_sel(vm_sel),
      .card_present(card_present), .ready(ready), .audio_in_data(audio_in_data),
      .audio_out_data(audio_out_data), .vm_status(vm_status), .msg_count(msg_count),
      .overflow(overflow), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int exp_waddr[$];
   int exp_wdata[$];
   int exp_audio[$];
   bit aud_chk = 1'b0;
   bit stall = 1'b0;
   int rd_cnt = 0;
   logic [15:0] mem [2**AW];

   localparam logic [2:0] C_REC = 3'd1, C_STOP = 3'd2, C_PLAY = 3'd3, C_DL = 3'd4, C_DA = 3'd5;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Memory model: ack 3 cycles after the request is seen; writes checked against the scoreboard.
   initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
   always begin
      int wcnt;
      @(posedge clk); #1;
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req && !stall) begin
         wcnt++;
         if (wcnt == 3) begin
            wcnt = 0;
            mem_ack = 1'b1;
            if (mem_we) begin
               mem[mem_addr] = mem_wdata;
               if (exp_waddr.size() == 0) chk("unexpected_write", int'(mem_addr), -1);
               else begin
                  chk("write_addr", int'(mem_addr), exp_waddr.pop_front());
                  chk("write_data", int'(mem_wdata), exp_wdata.pop_front());
               end
            end else begin
               mem_rdata = mem[mem_addr];
               rd_cnt++;
            end
         end
      end else wcnt = 0;
   end

   // Playback monitor: each ready during a checked playback yields one expected sample.
   always begin
      @(posedge clk);
      if (ready && aud_chk) begin
         #1;
         if (exp_audio.size() == 0) chk("unexpected_audio", int'(audio_out_data), -1);
         else chk("audio_out", int'(audio_out_data), exp_audio.pop_front());
      end
   end

   task automatic cmd(input logic [2:0] c, input logic [2:0] sel);
      @(negedge clk); vm_cmd = c; vm_sel = sel; vm_cmd_stb = 1'b1;
      @(negedge clk); vm_cmd_stb = 1'b0; vm_cmd = '0;
   endtask

   task automatic tick(input logic [15:0] d, input int gap);
      @(negedge clk); audio_in_data = d; ready = 1'b1;
      @(negedge clk); ready = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 3000 && vm_status != 4'd1; i++) @(negedge clk);
      chk(nm, int'(vm_status), 1);
   endtask

   task automatic record_msg(input int slot, input int base, input int n, input int nexp,
                             input int gap);
      cmd(C_REC, 3'd0);
      for (int i = 0; i < nexp; i++) begin
         exp_waddr.push_back((slot << SL) | i);
         exp_wdata.push_back(base + i);
      end
      for (int i = 0; i < n; i++) tick(16'(base + i), gap);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nfull, rd0;
      repeat (3) @(negedge clk);
      chk("reset_status", int'(vm_status), 0);
      chk("reset_count", int'(msg_count), 0);
      chk("reset_req", int'(mem_req), 0);
      chk("reset_audio", int'(audio_out_data), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("card_idle", int'(vm_status), 1);

      // 10 samples into slot 0, then play them back
      record_msg(0, 1, 10, 10, 6);
      cmd(C_STOP, 3'd0);
      wait_idle("rec1_idle");
      chk("rec1_count", int'(msg_count), 1);

      for (int i = 1; i <= 10; i++) exp_audio.push_back(i);
      exp_audio.push_back(0);
      aud_chk = 1'b1;
      cmd(C_PLAY, 3'd0);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 11; i++) tick(16'h0, 11);
      wait_idle("play_idle");
      aud_chk = 1'b0;
      chk("play_drained", exp_audio.size(), 0);
      chk("play_no_underrun", int'(overflow), 0);

      // stalled storage: 16-word FIFO absorbs 16 samples, rest dropped
      stall = 1'b1;
      record_msg(1, 16'h100, 40, 16, 2);
      chk("stall_overflow", int'(overflow), 1);
      stall = 1'b0;
      cmd(C_STOP, 3'd0);
      wait_idle("stall_idle");
      chk("stall_count", int'(msg_count), 2);

      // slot fills at 32 words and closes itself without STOP
      cmd(C_REC, 3'd0);
      chk("rec_clears_overflow", int'(overflow), 0);
      for (int i = 0; i < 32; i++) begin
         exp_waddr.push_back((2 << SL) | i);
         exp_wdata.push_back(16'h200 + i);
      end
      for (int i = 0; i < 40; i++) tick(16'(16'h200 + i), 6);
      wait_idle("slotfull_idle");
      chk("slotfull_count", int'(msg_count), 3);
      chk("slotfull_no_overflow", int'(overflow), 0);

      // zero-length messages fill slots 3..7
      for (int s = 3; s < 8; s++) begin
         cmd(C_REC, 3'd0);
         cmd(C_STOP, 3'd0);
         wait_idle("zlen_idle");
      end
      chk("full_count", int'(msg_count), 8);

      rd0 = rd_cnt;
      cmd(C_PLAY, 3'd3);
      repeat (4) @(negedge clk);
      chk("zlen_play_idle", int'(vm_status), 1);
      chk("zlen_play_noread", rd_cnt, rd0);

      vm_cmd = C_REC; vm_cmd_stb = 1'b1;
      @(negedge clk); vm_cmd_stb = 1'b0; vm_cmd = '0;
      nfull = 0;
      for (int i = 0; i < 5; i++) begin
         if (vm_status == 4'd5) nfull++;
         @(negedge clk);
      end
      chk("full_pulse_cycles", nfull, 1);
      chk("full_count_kept", int'(msg_count), 8);
      chk("full_back_idle", int'(vm_status), 1);

      cmd(C_DL, 3'd0);
      chk("del_last", int'(msg_count), 7);
      cmd(C_DA, 3'd0);
      chk("del_all", int'(msg_count), 0);

      rd0 = rd_cnt;
      cmd(C_PLAY, 3'd0);
      repeat (4) @(negedge clk);
      chk("play_invalid_idle", int'(vm_status), 1);
      chk("play_invalid_noread", rd_cnt, rd0);

      // card pulled mid-playback with a read outstanding
      record_msg(0, 16'hA1, 3, 3, 6);
      cmd(C_STOP, 3'd0);
      wait_idle("rec_last_idle");
      cmd(C_PLAY, 3'd0);
      for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
      chk("card_req_seen", int'(mem_req), 1);
      card_present = 1'b0;
      @(negedge clk);
      chk("card_req_drop", int'(mem_req), 0);
      chk("card_status", int'(vm_status), 0);
      chk("card_count", int'(msg_count), 0);
      chk("card_audio", int'(audio_out_data), 0);
      card_present = 1'b1;
      wait_idle("card_back_idle");

      repeat (10) @(negedge clk);
      chk("writes_outstanding", exp_waddr.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
